// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector with run-time pattern reload and overlap select.
// Optional saturating match counter built only when SEQDET_COUNT_EN is defined.
module seq_detect_param #(
    parameter int unsigned                PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0]     PATTERN     = 4'b0011,
    parameter int unsigned                CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   w,
    input  logic                   overlap,
    input  logic                   pat_load,
    input  logic [PATTERN_LEN-1:0] pat_in,
    input  logic                   cnt_clr,
    output logic                   z,
    output logic                   z_q,
    output logic [CNT_WIDTH-1:0]   match_count
);

    localparam int unsigned FW = $clog2(PATTERN_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(PATTERN_LEN - 1);

    logic [PATTERN_LEN-1:0] pat_q,  pat_d;
    logic [PATTERN_LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [PATTERN_LEN-1:0] cand;

    // Window of history plus the current bit; slicing it avoids a negative range when PATTERN_LEN=2.
    assign cand = {hist_q, w};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = cand[PATTERN_LEN-2:0];
            if (z && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    always_comb begin
        z = en && !pat_load && (fill_q == FILL_MAX) && (cand == pat_q);
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (z && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    assign match_count = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios then random traffic,
// checked against a queue-based model of accepted bits.
module tb_seq_detect_param;

    localparam int unsigned L = 4;
`ifdef SEQDET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, en, w, overlap, pat_load, cnt_clr;
    logic [L-1:0] pat_in;
    logic         z, z_q, z2, z_q2;
    logic [7:0]   mc;
    logic [1:0]   mc2;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Model state: accepted bits since last reset/load/non-overlap match.
    int unsigned q[$];
    int unsigned mpat;
    int unsigned mcnt, mcnt2;
    bit          mzq;
    bit          last_z;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .reset(reset), .en(en), .w(w), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .z(z), .z_q(z_q), .match_count(mc)
    );

    seq_detect_param #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .w(w), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .z(z2), .z_q(z_q2), .match_count(mc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_z(input bit e, input bit wi, input bit ld);
        int unsigned v;
        if (!e || ld || q.size() < L - 1) return 1'b0;
        v = 0;
        for (int i = q.size() - (L - 1); i < q.size(); i++) v = v * 2 + q[i];
        v = v * 2 + wi;
        return v == mpat;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_zq"},  z_q,  mzq);
        chk({tag, "_zq2"}, z_q2, mzq);
        chk({tag, "_cnt"}, mc,   CNT_EN ? mcnt  : 0);
        chk({tag, "_cnt2"}, mc2, CNT_EN ? mcnt2 : 0);
    endtask

    task automatic step(input bit e, input bit wi, input bit ov, input bit ld,
                        input logic [L-1:0] pi, input bit clr);
        bit ez;
        en = e; w = wi; overlap = ov; pat_load = ld; pat_in = pi; cnt_clr = clr;
        #1;
        ez = model_z(e, wi, ld);
        chk("z", z, ez);
        chk("z2", z2, ez);
        last_z = z;
        @(posedge clk);
        mzq = ez;
        if (clr) begin
            mcnt = 0; mcnt2 = 0;
        end else if (ez) begin
            if (mcnt  < 255) mcnt++;
            if (mcnt2 < 3)   mcnt2++;
        end
        if (ld) begin
            mpat = pi; q.delete();
        end else if (e) begin
            if (ez && !ov) q.delete();
            else begin
                q.push_back(wi);
                if (q.size() > 16) void'(q.pop_front());
            end
        end
        #1;
        check_regs("step");
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b1; w = 1'b1; pat_load = 1'b0; cnt_clr = 1'b0;
        #1;
        chk("rst_z", z, 0);
        @(posedge clk);
        #1;
        q.delete(); mpat = 4'b0011; mcnt = 0; mcnt2 = 0; mzq = 1'b0;
        chk("rst_z_hold", z, 0);
        check_regs("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic feed(input logic [7:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(1, bits[i], ov, 0, '0, 0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; w = 1'b0; overlap = 1'b1; pat_load = 1'b0;
        pat_in = '0; cnt_clr = 1'b0; last_z = 1'b0;
        @(negedge clk);
        do_reset();

        // Default pattern 0011, overlap on.
        feed(8'b0001, 3, 1);
        chk("s1_pre", last_z, 0);
        step(1, 1, 1, 0, '0, 0);
        chk("s1_match", last_z, 1);
        chk("s1_cnt", mc, CNT_EN ? 1 : 0);
        step(1, 0, 1, 0, '0, 0);
        chk("s1_after", last_z, 0);

        // Pattern 0101 overlapping, then non-overlapping.
        step(1, 1, 1, 1, 4'b0101, 1);
        chk("s2_load_z", last_z, 0);
        feed(8'b010101, 6, 1);
        chk("s2_last", last_z, 1);
        chk("s2_cnt", mc, CNT_EN ? 2 : 0);
        step(0, 0, 0, 1, 4'b0101, 1);
        feed(8'b010101, 6, 0);
        chk("s2n_last", last_z, 0);
        chk("s2n_cnt", mc, CNT_EN ? 1 : 0);

        // Enable gating with pattern 0011.
        step(1, 0, 1, 1, 4'b0011, 0);
        feed(8'b00, 2, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, i[0], 1, 0, '0, 0);
            chk("s3_en0", last_z, 0);
        end
        feed(8'b11, 2, 1);
        chk("s3_match", last_z, 1);

        // Mid-stream reset discards the partial match.
        feed(8'b001, 3, 1);
        do_reset();
        step(1, 1, 1, 0, '0, 0);
        chk("s4_nomatch", last_z, 0);
        feed(8'b0011, 4, 1);
        chk("s4_match", last_z, 1);

        // Saturation on the 2-bit counter, then clear beating a match.
        for (int i = 0; i < 5; i++) feed(8'b0011, 4, 0);
        chk("s5_sat2", mc2, CNT_EN ? 3 : 0);
        feed(8'b001, 3, 0);
        step(1, 1, 0, 0, '0, 1);
        chk("s5_clr_match", last_z, 1);
        chk("s5_clr2", mc2, 0);
        chk("s5_clr", mc, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r == 0) do_reset();
            else step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 29) == 0,
                      ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'($urandom),
                      $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Mealy serial-pattern detector, the successor to the fixed 4-bit "0011" detector. Pattern length and value are set at elaboration. The pattern can be reloaded at run time, and overlapping or non-overlapping detection is selected per cycle. It sits on a serial bit stream next to the other FSM blocks. It drives a combinational Mealy match flag, a registered copy of that flag, and an optional saturating match counter.

## Interface
- `PATTERN_LEN`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b0011: reset-time pattern; the first-received bit is the MSB.
- `CNT_WIDTH`, default 8: match counter width; legal range 1..32.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `en` input 1: bit-valid qualifier; `w` is consumed only when `en`=1.
- `w` input 1: serial data bit.
- `overlap` input 1: 1 = overlapping detection, 0 = non-overlapping.
- `pat_load` input 1: loads `pat_in` as the new pattern.
- `pat_in` input PATTERN_LEN: run-time pattern value.
- `cnt_clr` input 1: synchronous clear of the match counter.
- `z` output 1: Mealy match flag, combinational from `w` and state.
- `z_q` output 1: `z` registered; it is high the cycle after a match.
- `match_count` output CNT_WIDTH: saturating count of matches.

## Operation
- State:
  - `pat_r` (PATTERN_LEN bits);
  - `hist` (PATTERN_LEN-1 bits): previous accepted bits, newest in the LSB;
  - `fill` (0..PATTERN_LEN-1): number of valid history bits.
- `z` = `en` & !`pat_load` & (`fill`==PATTERN_LEN-1) & ({`hist`,`w`}==`pat_r`).
- Accepted bit (`en`=1, `pat_load`=0):
  - `hist` <= {`hist`[PATTERN_LEN-3:0], `w`};
  - `fill` increments and saturates at PATTERN_LEN-1.
- On a match with `overlap`=0: `fill` <= 0, so the next match needs PATTERN_LEN fresh bits.
- On a match with `overlap`=1: `fill` stays saturated, so shared suffix bits count again.
- `en`=0: `hist`, `fill` and `pat_r` hold; `z`=0.
- `pat_load`=1:
  - `pat_r` <= `pat_in`; `hist` <= 0; `fill` <= 0; `z`=0.
  - `w` is ignored that cycle, even if `en`=1.
- `z_q` <= `z` every cycle.
- Counter:
  - `match_count` increments on edges where `z`=1 and saturates at 2^CNT_WIDTH-1.
  - `cnt_clr` takes priority: a simultaneous match leaves the count at 0.
  - `cnt_clr` does not affect detection state.

## Timing
- `z` latency is zero cycles: valid in the same cycle the final pattern bit is presented.
- `z_q` and `match_count` update at the following rising edge.
- Reset values: `pat_r`=PATTERN, `hist`=0, `fill`=0, `z_q`=0, `match_count`=0.
  - `z`=0 while `fill`<PATTERN_LEN-1, which includes the whole reset period.
- Reset mid-stream discards any partial match; the next match needs PATTERN_LEN accepted bits after `reset` falls.
- No match is possible in the first PATTERN_LEN-1 accepted bits after reset or `pat_load`. This holds even if the zero-filled `hist` would compare equal.

## Configuration
- `SEQDET_COUNT_EN` defined: the match counter and `cnt_clr` logic are built.
- `SEQDET_COUNT_EN` undefined:
  - `match_count` is tied to 0;
  - `cnt_clr` is ignored;
  - detection, `z` and `z_q` are unchanged.

## Test plan
- Defaults, `overlap`=1, `en`=1, w=0,0,1,1 -> `z`=1 only while the 4th bit is presented; `z_q`=1 the next cycle; `match_count`=1.
- `pat_load` with `pat_in`=4'b0101, `overlap`=1, w=0,1,0,1,0,1 -> `z` high on bits 4 and 6; `match_count`=2. Same stream with `overlap`=0 -> `z` high on bit 4 only; `match_count`=1.
- w=0,0 then `en`=0 for 3 cycles with w toggling, then `en`=1 with w=1,1 -> `z` high on the last bit; no `z` while `en`=0.
- w=0,0,1, assert `reset` for one cycle, then w=1 -> `z` stays 0. Then w=0,0,1,1 -> match.
- CNT_WIDTH=2, five matches -> `match_count` saturates at 3. `cnt_clr` together with a 6th match -> `match_count`=0.
- Build without `SEQDET_COUNT_EN`, repeat the first scenario -> `z` and `z_q` identical; `match_count`=0 throughout.
